// File: rtl/tlp_trigger_param.sv
// -----------------------------------------------------------------------------
// tlp_trigger_param
//   Watches the committed write pointer (clk156 domain) and the committed read
//   pointer (250 MHz PCIe domain) of the RX buffer. Requests full-payload TLPs,
//   flushes partial data after a programmable timeout, and tracks the write
//   offset inside the current host huge page so that a page change is
//   requested before the page would overflow.
//
// Ports
//   clk156, reset_n                 : clock, asynchronous active-low reset
//   enable                          : 0 = no new transaction starts
//   timeout_cycles                  : flush timeout in clk156 cycles (0 = off)
//   commited_wr_address             : write pointer (clk156 domain)
//   commited_rd_address             : read pointer (250 MHz, Gray-stable)
//   trigger_tlp_ack                 : 250 MHz level ack of trigger_tlp
//   change_huge_page_ack            : 250 MHz level ack of change_huge_page
//   trigger_tlp                     : TLP request (four-phase)
//   change_huge_page                : page-change request (four-phase)
//   send_last_tlp_change_huge_page  : this TLP closes the page
//   qwords_to_send                  : TLP payload size in QWORDs
//   tlp_page_offset                 : QWORD offset of this TLP in the page
//   pages_completed                 : wrapping count of completed page changes
//   commited_rd_address_out         : synchronised read pointer
//   commited_wr_address_out         : write pointer, combinational pass-through
// -----------------------------------------------------------------------------
module tlp_trigger_param #(
    parameter int ADDR_W            = 10,
    parameter int MAX_PL_QW         = 16,
    parameter int PAGE_LOG2         = 18,
    parameter int PAGE_HDR_QW       = 16,
    parameter int FLUSH_CLOSES_PAGE = 1
) (
    input  logic                           clk156,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [27:0]                    timeout_cycles,
    input  logic [ADDR_W-1:0]              commited_wr_address,
    input  logic [ADDR_W-1:0]              commited_rd_address,
    input  logic                           trigger_tlp_ack,
    input  logic                           change_huge_page_ack,
    output logic                           trigger_tlp,
    output logic                           change_huge_page,
    output logic                           send_last_tlp_change_huge_page,
    output logic [$clog2(MAX_PL_QW):0]     qwords_to_send,
    output logic [PAGE_LOG2-1:0]           tlp_page_offset,
    output logic [15:0]                    pages_completed,
    output logic [ADDR_W-1:0]              commited_rd_address_out,
    output logic [ADDR_W-1:0]              commited_wr_address_out
);

    localparam int QW_W  = $clog2(MAX_PL_QW) + 1;
    // One extra bit so that an offset of exactly one full page is representable
    localparam int OFF_W = PAGE_LOG2 + 1;

    localparam logic [OFF_W-1:0]  PAGE_SIZE  = {1'b1, {PAGE_LOG2{1'b0}}};
    localparam logic [OFF_W-1:0]  PAGE_HDR   = OFF_W'(PAGE_HDR_QW);
    localparam logic [ADDR_W-1:0] MAX_PL_A   = ADDR_W'(MAX_PL_QW);
    localparam logic [QW_W-1:0]   MAX_PL_Q   = QW_W'(MAX_PL_QW);
    localparam logic [27:0]       TIMER_MAX  = {28{1'b1}};
    localparam logic              CLOSE_EN   = (FLUSH_CLOSES_PAGE != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        TLP_HI = 3'd2,
        TLP_LO = 3'd3,
        CHG_HI = 3'd4,
        CHG_LO = 3'd5
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] rd_meta_r, rd_s_r;
    logic              tack_meta_r, tack_s_r;
    logic              cack_meta_r, cack_s_r;
    logic [ADDR_W-1:0] diff_r;
    logic [27:0]       timer_r;
    logic [QW_W-1:0]   n_r;
    logic              flush_r;
    logic              forced_r;
    logic [OFF_W-1:0]  page_off_r;

    logic              diff_nz_s;
    logic              diff_full_s;
    logic              start_full_s;
    logic              start_flush_s;
    logic [OFF_W-1:0]  page_end_s;
    logic              overflow_s;

    assign commited_rd_address_out = rd_s_r;
    assign commited_wr_address_out = commited_wr_address;

    // Start conditions and page-overflow check for the next TLP
    always_comb begin
        diff_nz_s     = (diff_r != {ADDR_W{1'b0}});
        diff_full_s   = (diff_r >= MAX_PL_A);
        start_full_s  = 1'b0;
        start_flush_s = 1'b0;
        if (enable && diff_full_s) begin
            start_full_s = 1'b1;
        end else if (enable && (timeout_cycles != 28'd0) &&
                     (timer_r >= timeout_cycles) && diff_nz_s) begin
            start_flush_s = 1'b1;
        end else begin
            start_full_s  = 1'b0;
            start_flush_s = 1'b0;
        end
        page_end_s = page_off_r + OFF_W'(n_r);
        overflow_s = (page_end_s > PAGE_SIZE);
    end

    // Two-flop synchronisers for the PCIe-domain read pointer and acks
    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            rd_meta_r   <= {ADDR_W{1'b0}};
            rd_s_r      <= {ADDR_W{1'b0}};
            tack_meta_r <= 1'b0;
            tack_s_r    <= 1'b0;
            cack_meta_r <= 1'b0;
            cack_s_r    <= 1'b0;
        end else begin
            rd_meta_r   <= commited_rd_address;
            rd_s_r      <= rd_meta_r;
            tack_meta_r <= trigger_tlp_ack;
            tack_s_r    <= tack_meta_r;
            cack_meta_r <= change_huge_page_ack;
            cack_s_r    <= cack_meta_r;
        end
    end

    // Pending QWORD count; modular subtraction absorbs pointer wrap
    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            diff_r <= {ADDR_W{1'b0}};
        end else begin
            diff_r <= commited_wr_address - rd_s_r;
        end
    end

    // Saturating flush timer: counts idle cycles with a partial payload pending
    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= 28'd0;
        end else if ((state_r == IDLE) && !start_full_s && !start_flush_s &&
                     diff_nz_s && !diff_full_s) begin
            if (timer_r != TIMER_MAX) begin
                timer_r <= timer_r + 28'd1;
            end
        end else begin
            timer_r <= 28'd0;
        end
    end

    // Request FSM with registered handshake outputs and page bookkeeping
    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) begin
            state_r                        <= IDLE;
            n_r                            <= {QW_W{1'b0}};
            flush_r                        <= 1'b0;
            forced_r                       <= 1'b0;
            page_off_r                     <= PAGE_HDR;
            trigger_tlp                    <= 1'b0;
            change_huge_page               <= 1'b0;
            send_last_tlp_change_huge_page <= 1'b0;
            qwords_to_send                 <= {QW_W{1'b0}};
            tlp_page_offset                <= {PAGE_LOG2{1'b0}};
            pages_completed                <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_full_s) begin
                        n_r     <= MAX_PL_Q;
                        flush_r <= 1'b0;
                        state_r <= CHECK;
                    end else if (start_flush_s) begin
                        // diff < MAX_PL_QW here, so it fits the payload width
                        n_r     <= diff_r[QW_W-1:0];
                        flush_r <= 1'b1;
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (overflow_s) begin
                        change_huge_page <= 1'b1;
                        forced_r         <= 1'b1;
                        state_r          <= CHG_HI;
                    end else begin
                        qwords_to_send                 <= n_r;
                        tlp_page_offset                <= page_off_r[PAGE_LOG2-1:0];
                        send_last_tlp_change_huge_page <= flush_r & CLOSE_EN;
                        trigger_tlp                    <= 1'b1;
                        state_r                        <= TLP_HI;
                    end
                end
                TLP_HI: begin
                    if (tack_s_r) begin
                        trigger_tlp <= 1'b0;
                        page_off_r  <= page_off_r + OFF_W'(qwords_to_send);
                        state_r     <= TLP_LO;
                    end
                end
                TLP_LO: begin
                    if (!tack_s_r) begin
                        if (send_last_tlp_change_huge_page) begin
                            send_last_tlp_change_huge_page <= 1'b0;
                            change_huge_page               <= 1'b1;
                            forced_r                       <= 1'b0;
                            state_r                        <= CHG_HI;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                CHG_HI: begin
                    if (cack_s_r) begin
                        change_huge_page <= 1'b0;
                        page_off_r       <= PAGE_HDR;
                        pages_completed  <= pages_completed + 16'd1;
                        state_r          <= CHG_LO;
                    end
                end
                CHG_LO: begin
                    if (!cack_s_r) begin
                        // A forced change retries the same payload on the new page
                        state_r <= forced_r ? CHECK : IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlp_trigger_param.sv
// -----------------------------------------------------------------------------
// tb_tlp_trigger_param
//   Self-checking bench for tlp_trigger_param. The DUT uses a 64-QWORD page so
//   page boundaries are reached quickly. The bench acts as producer (moves the
//   write pointer) and as consumer (advances the read pointer, then acks). A
//   reference model predicts the ordered list of TLP / page-change requests
//   from the pending QWORD count, the page offset and the flush timeout.
// -----------------------------------------------------------------------------
module tb_tlp_trigger_param;

    localparam int AW  = 10;
    localparam int PG  = 6;
    localparam int QW  = 5;
    localparam int HDR = 16;
    localparam int MPL = 16;
    localparam int PSZ = 64;

    logic          clk156 = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [27:0]   timeout_cycles;
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic          tack;
    logic          cack;
    logic          trigger_tlp;
    logic          change_huge_page;
    logic          send_last;
    logic [QW-1:0] qwords_to_send;
    logic [PG-1:0] tlp_page_offset;
    logic [15:0]   pages_completed;
    logic [AW-1:0] rd_out;
    logic [AW-1:0] wr_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit is_chg;
        int n;
        int off;
        bit last;
        int pages;
    } ev_t;

    ev_t exp_q[$];
    int  m_off;
    int  m_pages;
    int  m_pend;
    int  m_timeout;

    tlp_trigger_param #(
        .ADDR_W(AW), .MAX_PL_QW(MPL), .PAGE_LOG2(PG),
        .PAGE_HDR_QW(HDR), .FLUSH_CLOSES_PAGE(1)
    ) dut (
        .clk156                         (clk156),
        .reset_n                        (reset_n),
        .enable                         (enable),
        .timeout_cycles                 (timeout_cycles),
        .commited_wr_address            (wr_q),
        .commited_rd_address            (rd_q),
        .trigger_tlp_ack                (tack),
        .change_huge_page_ack           (cack),
        .trigger_tlp                    (trigger_tlp),
        .change_huge_page               (change_huge_page),
        .send_last_tlp_change_huge_page (send_last),
        .qwords_to_send                 (qwords_to_send),
        .tlp_page_offset                (tlp_page_offset),
        .pages_completed                (pages_completed),
        .commited_rd_address_out        (rd_out),
        .commited_wr_address_out        (wr_out)
    );

    always #5 clk156 = ~clk156;

    // ---------------- reference model ----------------
    function automatic void push_ev(input bit c, input int n, input int off, input bit last);
        ev_t e;
        e.is_chg = c; e.n = n; e.off = off; e.last = last; e.pages = m_pages;
        exp_q.push_back(e);
    endfunction

    // One TLP of n QWORDs; a page change precedes it if it would not fit,
    // and a closing flush is followed by a page change.
    function automatic void m_tlp(input int n, input bit last);
        if (m_off + n > PSZ) begin
            m_off = HDR; m_pages = (m_pages + 1) % 65536;
            push_ev(1'b1, 0, 0, 1'b0);
        end
        push_ev(1'b0, n, m_off, last);
        m_off = m_off + n;
        if (last) begin
            m_off = HDR; m_pages = (m_pages + 1) % 65536;
            push_ev(1'b1, 0, 0, 1'b0);
        end
    endfunction

    function automatic void m_add(input int k);
        m_pend = m_pend + k;
        while (m_pend >= MPL) begin
            m_tlp(MPL, 1'b0);
            m_pend = m_pend - MPL;
        end
        if (m_pend > 0 && m_timeout != 0) begin
            m_tlp(m_pend, 1'b1);
            m_pend = 0;
        end
    endfunction

    // ---------------- consumer / scenario driver ----------------
    task automatic serve(input int hold_extra, input int quiet);
        ev_t           e;
        int            budget;
        bit            is_chg;
        bit            stable;
        bit            bad;
        logic [QW-1:0] q0;
        logic [PG-1:0] o0;
        logic          l0;
        while (exp_q.size() != 0) begin
            @(negedge clk156);
            budget = 0;
            while (!trigger_tlp && !change_huge_page && budget < 500) begin
                @(negedge clk156);
                budget++;
            end
            if (budget >= 500) begin
                n_cmp++; n_err++;
                $display("FAIL wait_request: no request after %0d cycles, %0d expected events left",
                         budget, exp_q.size());
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                is_chg = change_huge_page;
                n_cmp++;
                if ((trigger_tlp && change_huge_page) || (is_chg != e.is_chg)) begin
                    n_err++;
                    $display("FAIL request_kind: got tlp=%0b chg=%0b, expected chg=%0b",
                             trigger_tlp, change_huge_page, e.is_chg);
                end
                if (!is_chg) begin
                    n_cmp++;
                    if (qwords_to_send !== QW'(e.n) || tlp_page_offset !== PG'(e.off) ||
                        send_last !== e.last) begin
                        n_err++;
                        $display("FAIL tlp_fields: got qw=%0d off=%0d last=%0b, expected qw=%0d off=%0d last=%0b",
                                 qwords_to_send, tlp_page_offset, send_last, e.n, e.off, e.last);
                    end
                    q0 = qwords_to_send; o0 = tlp_page_offset; l0 = send_last;
                    rd_q = rd_q + AW'(qwords_to_send);
                    repeat ($urandom_range(1, 3)) @(negedge clk156);
                    tack = 1'b1;
                    budget = 0; stable = 1'b1;
                    while (trigger_tlp && budget < 50) begin
                        if (qwords_to_send !== q0 || tlp_page_offset !== o0 || send_last !== l0)
                            stable = 1'b0;
                        @(negedge clk156);
                        budget++;
                    end
                    n_cmp++;
                    if (trigger_tlp || !stable || budget == 0) begin
                        n_err++;
                        $display("FAIL tlp_release: trigger=%0b stable=%0b cycles=%0d, expected drop after ack with stable fields",
                                 trigger_tlp, stable, budget);
                    end
                end else begin
                    repeat ($urandom_range(1, 3)) @(negedge clk156);
                    cack = 1'b1;
                    budget = 0;
                    while (change_huge_page && budget < 50) begin
                        @(negedge clk156);
                        budget++;
                    end
                    n_cmp++;
                    if (change_huge_page || pages_completed !== 16'(e.pages)) begin
                        n_err++;
                        $display("FAIL chg_release: chg=%0b pages=%0d, expected chg=0 pages=%0d",
                                 change_huge_page, pages_completed, e.pages);
                    end
                end
                if (hold_extra > 0) begin
                    bad = 1'b0;
                    repeat (hold_extra) begin
                        @(negedge clk156);
                        if (trigger_tlp || change_huge_page) bad = 1'b1;
                    end
                    n_cmp++;
                    if (bad) begin
                        n_err++;
                        $display("FAIL ack_held: new request seen while ack still high, expected none");
                    end
                end
                tack = 1'b0;
                cack = 1'b0;
            end
        end
        bad = 1'b0;
        repeat (quiet) begin
            @(negedge clk156);
            if (trigger_tlp || change_huge_page) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL quiet: unexpected request tlp=%0b chg=%0b, expected none",
                     trigger_tlp, change_huge_page);
        end
    endtask

    task automatic do_reset();
        enable = 1'b0; tack = 1'b0; cack = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk156);
        reset_n = 1'b1;
        repeat (6) @(negedge clk156);
        m_off = HDR; m_pages = 0; exp_q.delete();
        m_pend = int'(AW'(wr_q - rd_q));
    endtask

    task automatic check_pages(input string name);
        n_cmp++;
        if (pages_completed !== 16'(m_pages)) begin
            n_err++;
            $display("FAIL %s_pages: got %0d, expected %0d", name, pages_completed, m_pages);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        wr_q = '0; rd_q = '0; timeout_cycles = 28'd0; m_timeout = 0;
        enable = 1'b0; tack = 1'b0; cack = 1'b0;
        reset_n = 1'b0;
        @(negedge clk156);
        n_cmp++;
        if ({trigger_tlp, change_huge_page, send_last} !== 3'b000 || qwords_to_send !== '0 ||
            tlp_page_offset !== '0 || pages_completed !== 16'd0 || rd_out !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: tlp=%0b chg=%0b last=%0b qw=%0d off=%0d pages=%0d rd=%0d, expected all 0",
                     trigger_tlp, change_huge_page, send_last, qwords_to_send,
                     tlp_page_offset, pages_completed, rd_out);
        end
        do_reset();
    endtask

    task automatic test_full_payload();
        enable = 1'b1;
        wr_q = wr_q + 10'd40;
        m_add(40);
        serve(0, 60);
        n_cmp++;
        if (rd_out !== 10'd32 || m_pend != 8) begin
            n_err++;
            $display("FAIL full_rd_out: got %0d, expected 32 (model pending %0d)", rd_out, m_pend);
        end
        n_cmp++;
        if (wr_out !== wr_q) begin
            n_err++;
            $display("FAIL wr_passthrough: got %0d, expected %0d", wr_out, wr_q);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        timeout_cycles = 28'd100; m_timeout = 100;
        m_add(0);
        serve(0, 40);
        check_pages("flush8");
        wr_q = wr_q + 10'd5;
        cnt = 0;
        while (!trigger_tlp && cnt < 300) begin
            @(negedge clk156);
            cnt++;
        end
        n_cmp++;
        if (cnt < 100 || cnt > 106) begin
            n_err++;
            $display("FAIL timeout_latency: trigger after %0d cycles, expected 100..106", cnt);
        end
        m_add(5);
        serve(0, 40);
        check_pages("flush5");
    endtask

    task automatic test_page_boundary();
        wr_q = wr_q + 10'd48;
        m_add(48);
        serve(0, 40);
        wr_q = wr_q + 10'd16;
        m_add(16);
        serve(0, 40);
        check_pages("boundary");
    endtask

    task automatic test_ack_held();
        wr_q = wr_q + 10'd32;
        m_add(32);
        serve(3, 40);
    endtask

    task automatic test_enable();
        bit bad = 1'b0;
        enable = 1'b0;
        wr_q = wr_q + 10'd20;
        repeat (150) begin
            @(negedge clk156);
            if (trigger_tlp || change_huge_page) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL enable_hold: request with enable=0, expected none");
        end
        m_add(20);
        enable = 1'b1;
        serve(0, 40);
        check_pages("enable");
    endtask

    task automatic test_wrap();
        wr_q = 10'd1020; rd_q = 10'd1020;
        do_reset();
        enable = 1'b1;
        wr_q = 10'd12;
        m_add(16);
        serve(0, 130);
        n_cmp++;
        if (rd_out !== 10'd12) begin
            n_err++;
            $display("FAIL wrap_rd_out: got %0d, expected 12", rd_out);
        end
    endtask

    task automatic test_reset_mid();
        int budget = 0;
        wr_q = wr_q + 10'd16;
        while (!trigger_tlp && budget < 100) begin
            @(negedge clk156);
            budget++;
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (trigger_tlp !== 1'b0 || change_huge_page !== 1'b0 || send_last !== 1'b0 ||
            qwords_to_send !== '0 || tlp_page_offset !== '0 || pages_completed !== 16'd0 ||
            budget >= 100) begin
            n_err++;
            $display("FAIL reset_mid: tlp=%0b chg=%0b qw=%0d off=%0d pages=%0d wait=%0d, expected all 0",
                     trigger_tlp, change_huge_page, qwords_to_send, tlp_page_offset,
                     pages_completed, budget);
        end
        do_reset();
        enable = 1'b1;
        m_add(0);
        serve(0, 40);
        check_pages("reset_mid");
    endtask

    task automatic test_random();
        int k;
        int t;
        for (int r = 0; r < 10; r++) begin
            k = $urandom_range(1, 40);
            t = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(10, 60);
            wr_q = wr_q + AW'(k);
            repeat (3) @(negedge clk156);
            timeout_cycles = 28'(t); m_timeout = t;
            m_add(k);
            serve($urandom_range(0, 2), t + 40);
        end
        timeout_cycles = 28'd30; m_timeout = 30;
        m_add(0);
        serve(0, 70);
        check_pages("random");
    endtask

    initial begin
        test_reset();
        test_full_payload();
        test_timeout();
        test_page_boundary();
        test_ack_held();
        test_enable();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
